// File: rtl/wb_interconnect_nx1_arb.sv
// N-initiator to 1-target Wishbone arbiter/mux with a registered round-robin grant held for the whole cycle.
// Optional stall timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_interconnect_nx1_arb #(
    parameter int ADR_WIDTH      = 32,
    parameter int DAT_WIDTH      = 32,
    parameter int N_INITIATORS   = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [N_INITIATORS*ADR_WIDTH-1:0]   t_adr,
    input  logic [N_INITIATORS*DAT_WIDTH-1:0]   t_dat_w,
    output logic [N_INITIATORS*DAT_WIDTH-1:0]   t_dat_r,
    input  logic [N_INITIATORS*DAT_WIDTH/8-1:0] t_sel,
    input  logic [N_INITIATORS-1:0]             t_cyc,
    input  logic [N_INITIATORS-1:0]             t_stb,
    input  logic [N_INITIATORS-1:0]             t_we,
    output logic [N_INITIATORS-1:0]             t_ack,
    output logic [N_INITIATORS-1:0]             t_err,
    output logic [ADR_WIDTH-1:0]                i_adr,
    output logic [DAT_WIDTH-1:0]                i_dat_w,
    output logic [DAT_WIDTH/8-1:0]              i_sel,
    output logic                                i_we,
    output logic                                i_cyc,
    output logic                                i_stb,
    input  logic [DAT_WIDTH-1:0]                i_dat_r,
    input  logic                                i_ack,
    input  logic                                i_err
);
    localparam int SEL_WIDTH = DAT_WIDTH / 8;
    localparam int GW        = (N_INITIATORS > 1) ? $clog2(N_INITIATORS) : 1;

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
`else
    typedef enum logic [0:0] {IDLE, BUSY} state_t;
`endif

    state_t        st, st_next;
    logic [GW-1:0] gnt, last, pick;
    logic          found;
    logic          tmo_hit;

    // Round-robin search starting just past the last winner, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = last;
        for (int i = 1; i <= N_INITIATORS; i++) begin
            if (!found && t_cyc[(int'(last) + i) % N_INITIATORS]) begin
                found = 1'b1;
                pick  = GW'((int'(last) + i) % N_INITIATORS);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st   <= IDLE;
            gnt  <= '0;
            last <= GW'(N_INITIATORS - 1);
        end else begin
            st <= st_next;
            if (st == IDLE && found) begin
                gnt  <= pick;
                last <= pick;
            end
        end
    end

    always_comb begin
        st_next = st;
        case (st)
            IDLE: if (found) st_next = BUSY;
            BUSY: begin
                if (!t_cyc[gnt])  st_next = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                else if (tmo_hit) st_next = ERR;
            end
            ERR: begin
                if (!t_cyc[gnt])  st_next = IDLE;
`endif
            end
            default: st_next = IDLE;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          err_first;
    logic          stall;

    assign stall   = (st == BUSY) && i_stb && !i_ack && !i_err;
    assign tmo_hit = stall && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            err_first <= 1'b0;
        end else begin
            if (st != BUSY || i_ack || i_err) cnt <= '0;
            else if (stall)                   cnt <= cnt + 1'b1;
            err_first <= (st == BUSY) && (st_next == ERR);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign t_dat_r = {N_INITIATORS{i_dat_r}};

    // The granted slice always drives the target-side payload; only cyc/stb are gated by state.
    always_comb begin
        i_adr   = t_adr[int'(gnt)*ADR_WIDTH +: ADR_WIDTH];
        i_dat_w = t_dat_w[int'(gnt)*DAT_WIDTH +: DAT_WIDTH];
        i_sel   = t_sel[int'(gnt)*SEL_WIDTH +: SEL_WIDTH];
        i_we    = t_we[gnt];
        i_cyc   = 1'b0;
        i_stb   = 1'b0;
        t_ack   = '0;
        t_err   = '0;
        if (st == BUSY) begin
            i_cyc      = t_cyc[gnt];
            i_stb      = t_stb[gnt];
            // An ack arriving after the initiator abandoned its cycle is dropped.
            t_ack[gnt] = i_ack & t_cyc[gnt];
            t_err[gnt] = i_err & t_cyc[gnt];
        end
`ifdef WB_ARB_TIMEOUT_EN
        if (st == ERR && err_first) t_err[gnt] = 1'b1;
`endif
    end

endmodule

// File: tb/tb_wb_interconnect_nx1_arb.sv
// Directed self-checking bench for wb_interconnect_nx1_arb (2 initiators, timeout 8 when WB_ARB_TIMEOUT_EN).
module tb_wb_interconnect_nx1_arb;
    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] t_adr, t_dat_w, t_dat_r;
    logic [7:0]  t_sel;
    logic [1:0]  t_cyc, t_stb, t_we, t_ack, t_err;
    logic [31:0] i_adr, i_dat_w, i_dat_r;
    logic [3:0]  i_sel;
    logic        i_we, i_cyc, i_stb, i_ack, i_err;

    int ncmp  = 0;
    int nfail = 0;
    logic [1:0] exp_ack;

    wb_interconnect_nx1_arb #(
        .ADR_WIDTH(32), .DAT_WIDTH(32), .N_INITIATORS(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock), .reset(reset),
        .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r), .t_sel(t_sel),
        .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_ack(t_ack), .t_err(t_err),
        .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_we(i_we),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_dat_r(i_dat_r), .i_ack(i_ack), .i_err(i_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        t_cyc   = 2'b11;
        t_stb   = 2'b11;
        t_we    = 2'b00;
        t_adr   = {32'h2222_0000, 32'h1111_0000};
        t_dat_w = {32'h0000_000B, 32'h0000_000A};
        t_sel   = 8'hFF;
        i_dat_r = '0;
        i_ack   = 1'b0;
        i_err   = 1'b0;

        // reset state
        #2;
        chk("rst_cyc", i_cyc, 0);
        chk("rst_stb", i_stb, 0);
        chk("rst_ack", t_ack, 0);
        chk("rst_adr", i_adr, 32'h1111_0000);
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk("first_gnt_cyc", i_cyc, 1);
        chk("first_gnt_adr", i_adr, 32'h1111_0000);
        chk("first_gnt_dat", i_dat_w, 32'h0000_000A);
        t_cyc = 2'b00;
        t_stb = 2'b00;
        #1 chk("drop_cyc_same", i_cyc, 0);
        tick();

        // single read by initiator 1
        t_adr[63:32] = 32'h0000_1000;
        t_cyc = 2'b10;
        t_stb = 2'b10;
        #1 chk("rd_latency", i_cyc, 0);
        tick();
        chk("rd_cyc", i_cyc, 1);
        chk("rd_adr", i_adr, 32'h0000_1000);
        chk("rd_noack", t_ack, 0);
        tick();
        tick();
        i_ack   = 1'b1;
        i_dat_r = 32'hCAFE_F00D;
        #1;
        chk("rd_ack", t_ack, 2'b10);
        chk("rd_dat", t_dat_r[63:32], 32'hCAFE_F00D);
        chk("rd_err", t_err, 0);
        tick();
        i_ack = 1'b0;
        t_cyc = 2'b00;
        t_stb = 2'b00;
        tick();

        // round-robin with both requesting: 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            t_cyc = 2'b11;
            t_stb = 2'b11;
            tick();
            chk("rr_cyc", i_cyc, 1);
            chk("rr_adr", i_adr, (k % 2) ? 32'h0000_1000 : 32'h1111_0000);
            i_ack   = 1'b1;
            exp_ack = 2'b01 << (k % 2);
            #1 chk("rr_ack", t_ack, exp_ack);
            tick();
            i_ack = 1'b0;
            t_cyc[k % 2] = 1'b0;
            t_stb[k % 2] = 1'b0;
            #1 chk("rr_release", i_cyc, 0);
            tick();
            chk("rr_idle_gap", i_cyc, 0);
        end

        // locked burst by initiator 0 while initiator 1 waits
        t_cyc = 2'b11;
        t_stb = 2'b11;
        tick();
        chk("burst_adr", i_adr, 32'h1111_0000);
        for (int b = 0; b < 4; b++) begin
            i_ack = 1'b1;
            #1 chk("burst_ack", t_ack, 2'b01);
            tick();
        end
        i_ack    = 1'b0;
        t_cyc[0] = 1'b0;
        t_stb[0] = 1'b0;
        #1;
        chk("burst_end_cyc", i_cyc, 0);
        chk("burst_end_ack", t_ack, 0);
        tick();
        chk("burst_idle_gap", i_cyc, 0);
        tick();
        chk("burst_next_cyc", i_cyc, 1);
        chk("burst_next_adr", i_adr, 32'h0000_1000);
        i_ack = 1'b1;
        #1 chk("burst_next_ack", t_ack, 2'b10);

        // reset mid-transfer
        reset = 1'b1;
        #1;
        chk("mid_rst_cyc", i_cyc, 0);
        chk("mid_rst_stb", i_stb, 0);
        chk("mid_rst_ack", t_ack, 0);
        i_ack = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        t_cyc = 2'b11;
        t_stb = 2'b11;
        tick();
        chk("post_rst_gnt", i_adr, 32'h1111_0000);
        t_cyc = 2'b00;
        t_stb = 2'b00;
        tick();
        t_cyc = 2'b10;
        t_stb = 2'b10;
        #1 chk("idle_after_drop", i_cyc, 0);

        // stalled target: initiator 1 granted, never acked
        tick();
        chk("stall_cyc1", i_cyc, 1);
        chk("stall_adr", i_adr, 32'h0000_1000);
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk("stall_cyc", i_cyc, 1);
            chk("stall_err", t_err, 0);
        end
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        chk("tmo_err", t_err, 2'b10);
        chk("tmo_cyc", i_cyc, 0);
        tick();
        chk("tmo_err_once", t_err, 0);
        chk("tmo_cyc_held", i_cyc, 0);
`else
        chk("hang_cyc", i_cyc, 1);
        chk("hang_err", t_err, 0);
        tick();
        chk("hang_cyc2", i_cyc, 1);
        chk("hang_stb", i_stb, 1);
`endif
        t_cyc = 2'b00;
        t_stb = 2'b00;
        #1 chk("final_release", i_cyc, 0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
